// File: rtl/cbd_collector_if.sv
// Stream/bus bundle between the CBD sampler, the collector and the coefficient RAM.
// The collector sits on the slave modport; the sampler/RAM side uses master.
interface cbd_collector_if #(
    parameter int IDX_W = 2
);
    logic [47:0]        i_coeffs;
    logic               i_coeffs_valid;
    logic               i_done;
    logic [IDX_W-1:0]   i_poly_idx;
    logic               i_err_clr;
    logic               o_wr_en;
    logic [IDX_W+3:0]   o_wr_addr;
    logic [191:0]       o_wr_data;
    logic               o_poly_done;
    logic               o_busy;
    logic               o_err;

    modport slave (
        input  i_coeffs, i_coeffs_valid, i_done, i_poly_idx, i_err_clr,
        output o_wr_en, o_wr_addr, o_wr_data, o_poly_done, o_busy, o_err
    );

    modport master (
        output i_coeffs, i_coeffs_valid, i_done, i_poly_idx, i_err_clr,
        input  o_wr_en, o_wr_addr, o_wr_data, o_poly_done, o_busy, o_err
    );
endinterface

// File: rtl/cbd_collector.sv
// Collects 16 beats of 16 signed CBD coefficients per polynomial, converts each to a
// residue mod Q and writes one RAM word per beat; flags protocol and range errors.
module cbd_collector #(
    parameter int Q     = 3329,
    parameter int IDX_W = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    cbd_collector_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_FILL      = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   slot_q, slot_d;
    logic               wr_en_q, wr_en_d;
    logic [IDX_W+3:0]   wr_addr_q, wr_addr_d;
    logic [191:0]       wr_data_q, wr_data_d;
    logic               poly_done_q, poly_done_d;
    logic               err_q, err_d;

    logic               accept;
    logic               full;
    logic               err_set;
    logic               conv_err;
    logic [191:0]       conv_data;

    // -4 cannot come from a legal eta<=3 sampler; it still maps to Q-4 but raises o_err.
    function automatic logic [11:0] to_residue(input logic [2:0] c);
        if (c[2]) to_residue = 12'(Q - 4 + int'(c[1:0]));
        else      to_residue = {10'd0, c[1:0]};
    endfunction

    // Input field 0 is the most significant triple; output coefficient 0 is the LSB word.
    always_comb begin
        logic [2:0] fld;
        conv_data = '0;
        conv_err  = 1'b0;
        for (int j = 0; j < 16; j++) begin
            fld = bus.i_coeffs[47-3*j -: 3];
            conv_data[12*j +: 12] = to_residue(fld);
            if (fld == 3'b100) conv_err = 1'b1;
        end
    end

    assign accept = bus.i_coeffs_valid && (state_q != S_WAIT_DONE);
    assign full   = (state_q == S_WAIT_DONE) ||
                    (accept && (state_q == S_FILL) && (cnt_q == 4'hF));

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_coeffs_valid) begin
                    slot_d  = bus.i_poly_idx;
                    cnt_d   = 4'd1;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (bus.i_coeffs_valid) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'hF) state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: ;
            default: state_d = S_IDLE;
        endcase
        // i_done always ends the polynomial; whether it ended cleanly is judged below.
        if (bus.i_done) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
        end
    end

    always_comb begin
        wr_en_d     = accept;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        if (accept) begin
            wr_addr_d = {(state_q == S_IDLE) ? bus.i_poly_idx : slot_q, cnt_q};
            wr_data_d = conv_data;
        end
        poly_done_d = bus.i_done && full;
        err_set     = (accept && conv_err) ||
                      (bus.i_coeffs_valid && (state_q == S_WAIT_DONE)) ||
                      (bus.i_done && !full);
        err_d       = err_set || (err_q && !bus.i_err_clr);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            slot_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            poly_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            slot_q      <= slot_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            poly_done_q <= poly_done_d;
            err_q       <= err_d;
        end
    end

    assign bus.o_wr_en     = wr_en_q;
    assign bus.o_wr_addr   = wr_addr_q;
    assign bus.o_wr_data   = wr_data_q;
    assign bus.o_poly_done = poly_done_q;
    assign bus.o_busy      = (state_q != S_IDLE);
    assign bus.o_err       = err_q;

endmodule
